// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory / MMIO unit: address map,
// load/store op encodings and the lane/extension helper functions.
package dmem_pkg;

    // Address map
    localparam logic [11:0] RAM_PREFIX      = 12'h001;
    localparam logic [31:0] KBD_STATUS_ADDR = 32'h0020_0000;
    localparam logic [31:0] KBD_DATA_ADDR   = 32'h0020_0004;
    localparam logic [31:0] CYCLE_ADDR      = 32'h0020_0008;
    localparam logic [31:0] LED_ADDR        = 32'h0020_000C;

    // funct3 encodings for loads/stores
    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_RAM,
        RGN_KBD_STATUS,
        RGN_KBD_DATA,
        RGN_CYCLE,
        RGN_LED
    } region_e;

    // MMIO registers are matched on the word address so that sub-word
    // accesses land on the same register.
    function automatic region_e decode_region(input logic [31:0] addr);
        region_e rgn;
        if (addr[31:20] == RAM_PREFIX) begin
            rgn = RGN_RAM;
        end else if (addr[31:2] == KBD_STATUS_ADDR[31:2]) begin
            rgn = RGN_KBD_STATUS;
        end else if (addr[31:2] == KBD_DATA_ADDR[31:2]) begin
            rgn = RGN_KBD_DATA;
        end else if (addr[31:2] == CYCLE_ADDR[31:2]) begin
            rgn = RGN_CYCLE;
        end else if (addr[31:2] == LED_ADDR[31:2]) begin
            rgn = RGN_LED;
        end else begin
            rgn = RGN_NONE;
        end
        return rgn;
    endfunction

    // Halves must be 2-byte aligned, words 4-byte aligned.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
        logic mis;
        case (op[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] op, input logic [1:0] lo);
        logic [3:0] be;
        case (op[1:0])
            2'b00:   be = 4'b0001 << lo;
            2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data arrives right-aligned; move it onto the addressed lanes.
    function automatic logic [31:0] store_align(input logic [31:0] data, input logic [1:0] lo);
        return data << {lo, 3'b000};
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  op,
                                                input logic [1:0]  lo);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {lo, 3'b000};
        case (op[1:0])
            2'b00:   res = op[2] ? {24'h00_0000, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   res = op[2] ? {16'h0000, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
            default: res = shifted;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_mmio_unit_if.sv
// CPU memory-stage bus between the pipeline and the data-memory unit.
interface dmem_mmio_unit_if;
    logic [31:0] addr;
    logic [31:0] datain;
    logic [2:0]  op;
    logic        we;
    logic        rd;
    logic [31:0] dataout;

    modport master (output addr, datain, op, we, rd, input dataout);
    modport slave  (input addr, datain, op, we, rd, output dataout);
endinterface

// File: rtl/kbd_fifo.sv
// Keyboard scan-code FIFO. Power-of-two depth, pointers wrap by overflow;
// push is refused when full and pop is ignored when empty.
module kbd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify push/pop against occupancy and compute next pointers and count
    always_comb begin
        do_push_s = push && (count_q != FULL_COUNT);
        do_pop_s  = pop && (count_q != {CNT_W{1'b0}});
        if (do_push_s) begin
            wptr_d = wptr_q + PTR_W'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (do_pop_s) begin
            rptr_d = rptr_q + PTR_W'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= {PTR_W{1'b0}};
            rptr_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clock) begin
        if (do_push_s && !reset) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == {CNT_W{1'b0}});
    assign head  = mem_q[rptr_q];

endmodule

// File: rtl/dmem_mmio_unit.sv
// Data memory plus memory-mapped peripherals (keyboard FIFO, cycle counter,
// LED register). Loads are registered with one-cycle latency and read the
// RAM before any same-cycle store; misaligned accesses are dropped and flagged.
module dmem_mmio_unit
    import dmem_pkg::*;
#(
    parameter int RAM_ADDR_W = 15,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    dmem_mmio_unit_if.slave    bus,
    input  logic               kbd_valid,
    input  logic [7:0]         kbd_data,
    output logic               kbd_ready,
    output logic [15:0]        led,
    output logic               err
);

    logic [31:0] ram_q [2**RAM_ADDR_W];

    region_e               rgn_s;
    logic                  misalign_s;
    logic [3:0]            be_s;
    logic [31:0]           wdata_s;
    logic [RAM_ADDR_W-1:0] ram_idx_s;
    logic                  ram_we_s;
    logic                  led_wr_s;
    logic [31:0]           rd_word_s;
    logic [31:0]           load_val_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [7:0]            fifo_head_s;

    logic [31:0] dataout_q, dataout_d;
    logic [15:0] led_q, led_d;
    logic        err_q, err_d;
    logic [31:0] cycle_q, cycle_d;

    // Decode the access: region, alignment, lane enables and write qualifiers
    always_comb begin
        rgn_s      = decode_region(bus.addr);
        misalign_s = is_misaligned(bus.op, bus.addr[1:0]);
        be_s       = byte_enable(bus.op, bus.addr[1:0]);
        wdata_s    = store_align(bus.datain, bus.addr[1:0]);
        ram_idx_s  = bus.addr[RAM_ADDR_W+1:2];
        ram_we_s   = bus.we && !misalign_s && !reset && (rgn_s == RGN_RAM);
        led_wr_s   = bus.we && !misalign_s && (rgn_s == RGN_LED);
        pop_s      = bus.rd && !misalign_s && !reset && (rgn_s == RGN_KBD_DATA)
                     && (bus.op == OP_LW) && !fifo_empty_s;
        push_s     = kbd_valid && !fifo_full_s;
    end

    // Select the addressed word and extract/extend the load result
    always_comb begin
        case (rgn_s)
            RGN_RAM:        rd_word_s = ram_q[ram_idx_s];
            RGN_KBD_STATUS: rd_word_s = {30'h0, fifo_full_s, !fifo_empty_s};
            RGN_KBD_DATA:   rd_word_s = fifo_empty_s ? 32'h0 : {24'h00_0000, fifo_head_s};
            RGN_CYCLE:      rd_word_s = cycle_q;
            RGN_LED:        rd_word_s = {16'h0000, led_q};
            default:        rd_word_s = 32'h0;
        endcase
        if (misalign_s) begin
            load_val_s = 32'h0;
        end else begin
            load_val_s = load_extend(rd_word_s, bus.op, bus.addr[1:0]);
        end
    end

    // Next-state for load result, LED lanes, sticky error and cycle counter
    always_comb begin
        if (bus.rd) begin
            dataout_d = load_val_s;
        end else begin
            dataout_d = dataout_q;
        end
        led_d = led_q;
        if (led_wr_s) begin
            if (be_s[0]) begin
                led_d[7:0] = wdata_s[7:0];
            end else begin
                led_d[7:0] = led_q[7:0];
            end
            if (be_s[1]) begin
                led_d[15:8] = wdata_s[15:8];
            end else begin
                led_d[15:8] = led_q[15:8];
            end
        end else begin
            led_d = led_q;
        end
        err_d   = err_q | ((bus.we | bus.rd) & misalign_s);
        cycle_d = cycle_q + 32'd1;
    end

    // Registered outputs and counters with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            dataout_q <= 32'h0;
            led_q     <= 16'h0000;
            err_q     <= 1'b0;
            cycle_q   <= 32'h0;
        end else begin
            dataout_q <= dataout_d;
            led_q     <= led_d;
            err_q     <= err_d;
            cycle_q   <= cycle_d;
        end
    end

    // RAM byte-lane writes; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (ram_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    ram_q[ram_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_kbd_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (kbd_data),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (fifo_head_s)
    );

    assign bus.dataout = dataout_q;
    assign kbd_ready   = !fifo_full_s;
    assign led         = led_q;
    assign err         = err_q;

endmodule

// File: tb/tb_dmem_mmio_unit.sv
// Bench for dmem_mmio_unit: directed scenarios plus randomized traffic,
// all checked every clock against a byte-level memory / queue model.
module tb_dmem_mmio_unit;
    import dmem_pkg::*;

    localparam int DEPTH = 8;
    localparam logic [31:0] RAM_BASE = 32'h0010_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] t_addr;
    logic [31:0] t_datain;
    logic [2:0]  t_op;
    logic        t_we;
    logic        t_rd;
    logic        t_kbd_valid;
    logic [7:0]  t_kbd_data;
    logic        kbd_ready;
    logic [15:0] led;
    logic        err;

    dmem_mmio_unit_if bus_if ();

    assign bus_if.addr   = t_addr;
    assign bus_if.datain = t_datain;
    assign bus_if.op     = t_op;
    assign bus_if.we     = t_we;
    assign bus_if.rd     = t_rd;

    dmem_mmio_unit #(
        .RAM_ADDR_W (15),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus_if.slave),
        .kbd_valid (t_kbd_valid),
        .kbd_data  (t_kbd_data),
        .kbd_ready (kbd_ready),
        .led       (led),
        .err       (err)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [7:0]  m_ram [int];
    logic [7:0]  m_q [$];
    logic [31:0] m_dataout;
    logic [15:0] m_led;
    logic        m_err;
    logic [31:0] m_cycle;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int op_size(input logic [2:0] op);
        if (op[1:0] == 2'b00) return 1;
        if (op[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Load as the programmer sees it: gather bytes, then extend.
    task automatic model_load(input logic [31:0] a, input logic [2:0] op, output logic [31:0] v);
        int sz;
        logic [31:0] word;
        logic [31:0] wa;
        sz = op_size(op);
        v  = 32'h0;
        wa = {a[31:2], 2'b00};
        if (a[31:20] == 12'h001) begin
            for (int k = 0; k < sz; k++) v = v | (32'(m_ram[int'(a[16:0]) + k]) << (8 * k));
        end else begin
            word = 32'h0;
            if (wa == KBD_STATUS_ADDR)   word = {30'h0, m_q.size() == DEPTH, m_q.size() != 0};
            else if (wa == KBD_DATA_ADDR) begin
                if (m_q.size() != 0) begin
                    word = {24'h0, m_q[0]};
                    if (op == OP_LW) void'(m_q.pop_front());
                end
            end
            else if (wa == CYCLE_ADDR)   word = m_cycle;
            else if (wa == LED_ADDR)     word = {16'h0, m_led};
            else                         word = 32'h0;
            word = word >> (8 * int'(a[1:0]));
            if (sz == 4) v = word;
            else         v = word & ((32'h1 << (8 * sz)) - 32'h1);
        end
        if (sz < 4 && !op[2] && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
    endtask

    task automatic model_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
        int sz;
        int lane;
        sz = op_size(op);
        for (int k = 0; k < sz; k++) begin
            if (a[31:20] == 12'h001) begin
                m_ram[int'(a[16:0]) + k] = d[8*k +: 8];
            end else if ({a[31:2], 2'b00} == LED_ADDR) begin
                lane = int'(a[1:0]) + k;
                if (lane < 2) m_led[8*lane +: 8] = d[8*k +: 8];
            end
        end
    endtask

    // One clock: advance the model with current inputs, then compare.
    task automatic step();
        logic [31:0] v;
        int  sz;
        bit  mis;
        int  pre_size;
        if (reset) begin
            m_dataout = 32'h0;
            m_q.delete();
            m_led   = 16'h0;
            m_err   = 1'b0;
            m_cycle = 32'h0;
        end else begin
            sz       = op_size(t_op);
            mis      = (int'(t_addr[1:0]) % sz) != 0;
            pre_size = m_q.size();
            if ((t_we || t_rd) && mis) m_err = 1'b1;
            if (t_rd) begin
                if (mis) m_dataout = 32'h0;
                else begin
                    model_load(t_addr, t_op, v);
                    m_dataout = v;
                end
            end
            if (t_we && !mis) model_store(t_addr, t_op, t_datain);
            if (t_kbd_valid && pre_size < DEPTH) m_q.push_back(t_kbd_data);
            m_cycle = m_cycle + 32'd1;
        end
        @(posedge clock);
        #1;
        check_val("dataout", bus_if.dataout, m_dataout);
        check_val("kbd_ready", 32'(kbd_ready), 32'(m_q.size() < DEPTH));
        check_val("led", 32'(led), 32'(m_led));
        check_val("err", 32'(err), 32'(m_err));
    endtask

    task automatic idle();
        t_we = 1'b0; t_rd = 1'b0; t_kbd_valid = 1'b0;
        step();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
        t_addr = a; t_op = op; t_datain = d; t_we = 1'b1; t_rd = 1'b0;
        step();
        t_we = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] op);
        t_addr = a; t_op = op; t_rd = 1'b1; t_we = 1'b0;
        step();
        t_rd = 1'b0;
    endtask

    initial begin
        logic [2:0] ops [5];
        int sz;
        ops[0] = OP_LB; ops[1] = OP_LH; ops[2] = OP_LW; ops[3] = OP_LBU; ops[4] = OP_LHU;

        reset = 1'b1; t_addr = 32'h0; t_datain = 32'h0; t_op = OP_LW;
        t_we = 1'b0; t_rd = 1'b0; t_kbd_valid = 1'b0; t_kbd_data = 8'h00;
        m_dataout = 32'h0; m_led = 16'h0; m_err = 1'b0; m_cycle = 32'h0;
        repeat (3) step();
        check_val("rst_dataout", bus_if.dataout, 32'h0);
        check_val("rst_ready", 32'(kbd_ready), 32'h1);
        reset = 1'b0;

        // Cycle counter after ten clocks out of reset, then LED writes
        repeat (10) idle();
        do_load(CYCLE_ADDR, OP_LW);
        check_val("cycle10", bus_if.dataout, 32'd10);
        do_store(LED_ADDR, OP_LW, 32'h0000_ABCD);
        check_val("led_sw", 32'(led), 32'h0000_ABCD);
        do_store(LED_ADDR + 32'd1, OP_LB, 32'h0000_0055);
        check_val("led_sb", 32'(led), 32'h0000_55CD);
        do_store(LED_ADDR + 32'd2, OP_LH, 32'h0000_FFFF);
        do_load(LED_ADDR, OP_LW);
        check_val("led_rd", bus_if.dataout, 32'h0000_55CD);

        // Sub-word loads and half store
        do_store(RAM_BASE, OP_LW, 32'hDEAD_BEEF);
        do_load(RAM_BASE + 32'd1, OP_LB);
        check_val("lb", bus_if.dataout, 32'hFFFF_FFBE);
        do_load(RAM_BASE + 32'd1, OP_LBU);
        check_val("lbu", bus_if.dataout, 32'h0000_00BE);
        do_load(RAM_BASE + 32'd2, OP_LH);
        check_val("lh", bus_if.dataout, 32'hFFFF_DEAD);
        do_store(RAM_BASE + 32'd2, OP_LH, 32'h0000_1234);
        do_load(RAM_BASE, OP_LW);
        check_val("sh_lw", bus_if.dataout, 32'h1234_BEEF);

        // Read-before-write on the same word
        t_addr = RAM_BASE; t_op = OP_LW; t_datain = 32'h0BAD_F00D; t_we = 1'b1; t_rd = 1'b1;
        step();
        check_val("rbw_old", bus_if.dataout, 32'h1234_BEEF);
        do_store(RAM_BASE, OP_LW, 32'h1234_BEEF);

        // Fill the keyboard FIFO past capacity, then drain it
        for (int i = 1; i <= 9; i++) begin
            t_we = 1'b0; t_rd = 1'b0; t_kbd_valid = 1'b1; t_kbd_data = 8'(i);
            step();
            if (i == 8) check_val("ready_full", 32'(kbd_ready), 32'h0);
        end
        t_kbd_valid = 1'b0;
        do_load(KBD_STATUS_ADDR, OP_LW);
        check_val("status_full", bus_if.dataout, 32'h3);
        for (int i = 1; i <= 9; i++) begin
            do_load(KBD_DATA_ADDR, OP_LW);
            check_val("kbd_pop", bus_if.dataout, (i <= 8) ? 32'(i) : 32'h0);
        end
        do_load(KBD_STATUS_ADDR, OP_LW);
        check_val("status_empty", bus_if.dataout, 32'h0);

        // Push and pop together: on empty, then on non-empty
        t_kbd_valid = 1'b1; t_kbd_data = 8'hA5;
        do_load(KBD_DATA_ADDR, OP_LW);
        check_val("pp_empty", bus_if.dataout, 32'h0);
        t_kbd_data = 8'h5A;
        do_load(KBD_DATA_ADDR, OP_LW);
        check_val("pp_mid", bus_if.dataout, 32'h0000_00A5);
        t_kbd_valid = 1'b0;
        do_load(KBD_STATUS_ADDR, OP_LW);
        check_val("pp_status", bus_if.dataout, 32'h1);

        // Misaligned accesses
        do_load(RAM_BASE + 32'd2, OP_LW);
        check_val("mis_lw", bus_if.dataout, 32'h0);
        check_val("mis_err", 32'(err), 32'h1);
        do_store(RAM_BASE + 32'd1, OP_LH, 32'hFFFF_FFFF);
        do_load(RAM_BASE, OP_LW);
        check_val("mis_nowr", bus_if.dataout, 32'h1234_BEEF);
        check_val("err_sticky", 32'(err), 32'h1);

        // Reset with a pending store and load; FIFO holds a byte beforehand
        reset = 1'b1; t_addr = RAM_BASE; t_op = OP_LW; t_datain = 32'hFFFF_FFFF;
        t_we = 1'b1; t_rd = 1'b1; t_kbd_valid = 1'b0;
        step();
        check_val("rst_dout", bus_if.dataout, 32'h0);
        check_val("rst_err", 32'(err), 32'h0);
        reset = 1'b0; t_we = 1'b0; t_rd = 1'b0;
        do_load(RAM_BASE, OP_LW);
        check_val("rst_ram", bus_if.dataout, 32'h1234_BEEF);
        do_load(KBD_STATUS_ADDR, OP_LW);
        check_val("rst_fifo", bus_if.dataout, 32'h0);

        // Randomized traffic over an initialized RAM window and all registers
        for (int w = 0; w < 16; w++) do_store(RAM_BASE + 32'(4 * w), OP_LW, $urandom);
        for (int n = 0; n < 600; n++) begin
            t_op = ops[$urandom_range(0, 4)];
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: t_addr = RAM_BASE + 32'($urandom_range(0, 63));
                6:       t_addr = KBD_STATUS_ADDR + 32'($urandom_range(0, 3));
                7:       t_addr = KBD_DATA_ADDR + (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h0);
                8:       t_addr = (($urandom_range(0, 1) == 0) ? CYCLE_ADDR : LED_ADDR) + 32'($urandom_range(0, 3));
                default: t_addr = 32'h0030_0000 + 32'($urandom_range(0, 15));
            endcase
            sz = op_size(t_op);
            if ($urandom_range(0, 4) != 0) t_addr = t_addr & ~(32'(sz) - 32'h1);
            if (t_addr[31:2] == KBD_DATA_ADDR[31:2] && $urandom_range(0, 1) == 0) t_op = OP_LW;
            t_datain    = $urandom;
            t_we        = ($urandom_range(0, 2) == 0);
            t_rd        = ($urandom_range(0, 1) == 0);
            t_kbd_valid = ($urandom_range(0, 1) == 0);
            t_kbd_data  = 8'($urandom);
            reset       = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
